// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: loads/stores/LL/SC over a single-outstanding
// request/ack data bus with big-endian lane steering and a timeout.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    input  logic        LLbit_i,
    input  logic        wb_LLbit_we,
    input  logic        wb_LLbit_value,
    input  logic [5:0]  stall,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic        mem_LLbit_we,
    output logic        mem_LLbit_value,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        stallreq,
    output logic        mem_err
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
    localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;
    localparam logic       STOP       = 1'b1;
    localparam logic [4:0] NOP_REG    = 5'b00000;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        rdata_buf;
    logic               err_buf;

    logic        is_byte, is_half, is_word, is_load, is_store, is_signed, is_mem;
    logic        is_ll, is_sc, llbit_eff, misaligned, sc_fail, need_bus;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata, load_val;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};

    // Operation decode
    always_comb begin
        is_byte   = (ex_aluop == EXE_LB_OP) || (ex_aluop == EXE_LBU_OP) || (ex_aluop == EXE_SB_OP);
        is_half   = (ex_aluop == EXE_LH_OP) || (ex_aluop == EXE_LHU_OP) || (ex_aluop == EXE_SH_OP);
        is_ll     = (ex_aluop == EXE_LL_OP);
        is_sc     = (ex_aluop == EXE_SC_OP);
        is_word   = (ex_aluop == EXE_LW_OP) || (ex_aluop == EXE_SW_OP) || is_ll || is_sc;
        is_load   = (ex_aluop == EXE_LB_OP) || (ex_aluop == EXE_LBU_OP) || (ex_aluop == EXE_LH_OP)
                 || (ex_aluop == EXE_LHU_OP) || (ex_aluop == EXE_LW_OP) || is_ll;
        is_store  = (ex_aluop == EXE_SB_OP) || (ex_aluop == EXE_SH_OP) || (ex_aluop == EXE_SW_OP) || is_sc;
        is_signed = (ex_aluop == EXE_LB_OP) || (ex_aluop == EXE_LH_OP);
        is_mem    = is_load || is_store;
    end

    assign llbit_eff  = wb_LLbit_we ? wb_LLbit_value : LLbit_i;
    assign misaligned = (is_half && ex_mem_addr[0]) || (is_word && (ex_mem_addr[1:0] != 2'b00));
    assign sc_fail    = is_sc && !misaligned && !llbit_eff;
    assign need_bus   = is_mem && !misaligned && !sc_fail;

    // Big-endian byte enables and replicated store data
    always_comb begin
        req_sel   = 4'b1111;
        req_wdata = ex_reg2;
        if (is_byte) begin
            req_sel   = 4'b1000 >> ex_mem_addr[1:0];
            req_wdata = {4{ex_reg2[7:0]}};
        end else if (is_half) begin
            req_sel   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
            req_wdata = {2{ex_reg2[15:0]}};
        end
    end

    // Lane extraction and extension of buffered read data
    always_comb begin
        case (ex_mem_addr[1:0])
            2'd0:    load_byte = rdata_buf[31:24];
            2'd1:    load_byte = rdata_buf[23:16];
            2'd2:    load_byte = rdata_buf[15:8];
            default: load_byte = rdata_buf[7:0];
        endcase
        load_half = ex_mem_addr[1] ? rdata_buf[15:0] : rdata_buf[31:16];
        if (is_byte)
            load_val = is_signed ? {{24{load_byte[7]}}, load_byte} : {24'b0, load_byte};
        else if (is_half)
            load_val = is_signed ? {{16{load_half[15]}}, load_half} : {16'b0, load_half};
        else
            load_val = rdata_buf;
    end

    always_comb begin
        mem_wd          = ex_wd;
        mem_wreg        = ex_wreg;
        mem_wdata       = ex_wdata;
        mem_hi          = ex_hi;
        mem_lo          = ex_lo;
        mem_whilo       = ex_whilo;
        mem_LLbit_we    = 1'b0;
        mem_LLbit_value = 1'b0;
        mem_err         = 1'b0;
        stallreq        = 1'b0;
        if (rst) begin
            mem_wd    = NOP_REG;
            mem_wreg  = 1'b0;
            mem_wdata = 32'b0;
            mem_hi    = 32'b0;
            mem_lo    = 32'b0;
            mem_whilo = 1'b0;
        end else if (is_mem) begin
            stallreq = need_bus && (state != DONE);
            if (misaligned) begin
                mem_wreg = 1'b0;
                mem_err  = 1'b1;
            end else if (sc_fail) begin
                mem_wreg  = 1'b1;
                mem_wdata = 32'b0;
            end else if (state != DONE) begin
                // Access still in flight: nothing valid to write back yet
                mem_wreg = 1'b0;
            end else if (err_buf) begin
                mem_wreg = 1'b0;
                mem_err  = 1'b1;
            end else if (is_load) begin
                mem_wdata       = load_val;
                mem_LLbit_we    = is_ll;
                mem_LLbit_value = is_ll;
            end else if (is_sc) begin
                mem_wreg        = 1'b1;
                mem_wdata       = 32'd1;
                mem_LLbit_we    = 1'b1;
                mem_LLbit_value = 1'b0;
            end else begin
                mem_wreg = 1'b0;
            end
        end
    end

    // Bus handshake state machine with timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'b0;
            dbus_sel   <= 4'b0;
            dbus_wdata <= 32'b0;
            rdata_buf  <= 32'b0;
            err_buf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (need_bus) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store;
                        dbus_addr  <= {ex_mem_addr[31:2], 2'b00};
                        dbus_sel   <= req_sel;
                        dbus_wdata <= req_wdata;
                        cnt        <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (dbus_ack) begin
                        rdata_buf <= dbus_rdata;
                        dbus_req  <= 1'b0;
                        state     <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        dbus_req <= 1'b0;
                        err_buf  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (stall[4] != STOP) begin
                        err_buf <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (timeout set to 4 cycles).
module tb_mem_access_stage;

    localparam logic [7:0] OP_OR  = 8'b0010_0101;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_LL  = 8'b1111_0000;
    localparam logic [7:0] OP_SC  = 8'b1111_1000;

    logic        clk, rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg, ex_whilo, LLbit_i, wb_LLbit_we, wb_LLbit_value, dbus_ack;
    logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2, dbus_rdata;
    logic [7:0]  ex_aluop;
    logic [5:0]  stall;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo, mem_LLbit_we, mem_LLbit_value;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        dbus_req, dbus_we, stallreq, mem_err;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_sel;

    int compared = 0;
    int mismatched = 0;

    int          n, b;
    logic [3:0]  cap_sel;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;

    mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .LLbit_i(LLbit_i), .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
        .stall(stall),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .mem_LLbit_we(mem_LLbit_we), .mem_LLbit_value(mem_LLbit_value),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
        .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .stallreq(stallreq), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        compared++;
        assert (obs === expd) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                          input logic [4:0] wd, input logic wreg);
        ex_aluop    = op;
        ex_mem_addr = addr;
        ex_reg2     = r2;
        ex_wd       = wd;
        ex_wreg     = wreg;
        #1;
    endtask

    // Runs one access from IDLE until stallreq drops; ack in the ack_delay-th BUSY cycle (0 = never)
    task automatic bus_access(input int ack_delay, input logic [31:0] rd);
        n = 0;
        b = 0;
        cap_sel = 4'b0; cap_addr = 32'b0; cap_wdata = 32'b0; cap_we = 1'b0;
        while (stallreq === 1'b1 && n < 40) begin
            n++;
            if (dbus_req === 1'b1) begin
                b++;
                if (b == 1) begin
                    cap_sel = dbus_sel; cap_addr = dbus_addr;
                    cap_wdata = dbus_wdata; cap_we = dbus_we;
                end
                if (b == ack_delay) begin
                    dbus_ack   = 1'b1;
                    dbus_rdata = rd;
                end
            end
            tick();
            dbus_ack = 1'b0;
        end
        chk("access_bounded", 32'(n < 40), 32'd1);
    endtask

    initial begin
        rst = 1'b1; stall = 6'b0; dbus_ack = 1'b0; dbus_rdata = 32'b0;
        LLbit_i = 1'b0; wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
        ex_hi = 32'h1111_0000; ex_lo = 32'h0000_2222; ex_whilo = 1'b1;
        ex_wdata = 32'hDEAD_BEEF;
        set_op(OP_OR, 32'h0, 32'h0, 5'd9, 1'b1);

        // Reset values
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_wd", 32'(mem_wd), 32'h0);
        chk("rst_wreg", 32'(mem_wreg), 32'h0);
        chk("rst_stallreq", 32'(stallreq), 32'h0);
        chk("rst_dbus_req", 32'(dbus_req), 32'h0);
        chk("rst_dbus_addr", dbus_addr, 32'h0);
        chk("rst_dbus_sel", 32'(dbus_sel), 32'h0);
        tick(); tick();
        #2 rst = 1'b0;
        #1;

        // Non-memory passthrough
        chk("pass_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("pass_wd", 32'(mem_wd), 32'd9);
        chk("pass_wreg", 32'(mem_wreg), 32'd1);
        chk("pass_hi", mem_hi, 32'h1111_0000);
        chk("pass_whilo", 32'(mem_whilo), 32'd1);
        chk("pass_llwe", 32'(mem_LLbit_we), 32'd0);
        chk("pass_stallreq", 32'(stallreq), 32'd0);
        ex_wdata = 32'h0;

        // LB / LBU at byte lane 3
        set_op(OP_LB, 32'h1003, 32'h0, 5'd5, 1'b1);
        chk("lb_idle_stallreq", 32'(stallreq), 32'd1);
        bus_access(3, 32'h1122_3380);
        chk("lb_stall_cycles", 32'(n), 32'd4);
        chk("lb_sel", 32'(cap_sel), 32'b0001);
        chk("lb_addr", cap_addr, 32'h1000);
        chk("lb_we", 32'(cap_we), 32'd0);
        chk("lb_req_dropped", 32'(dbus_req), 32'd0);
        chk("lb_wdata", mem_wdata, 32'hFFFF_FF80);
        chk("lb_wreg", 32'(mem_wreg), 32'd1);
        chk("lb_err", 32'(mem_err), 32'd0);
        tick();
        set_op(OP_LBU, 32'h1003, 32'h0, 5'd5, 1'b1);
        bus_access(3, 32'h1122_3380);
        chk("lbu_stall_cycles", 32'(n), 32'd4);
        chk("lbu_wdata", mem_wdata, 32'h0000_0080);
        tick();

        // Halfword loads, both lanes
        set_op(OP_LH, 32'h1002, 32'h0, 5'd5, 1'b1);
        bus_access(1, 32'h1234_8001);
        chk("lh_stall_cycles", 32'(n), 32'd2);
        chk("lh_sel", 32'(cap_sel), 32'b0011);
        chk("lh_wdata", mem_wdata, 32'hFFFF_8001);
        tick();
        set_op(OP_LHU, 32'h1000, 32'h0, 5'd5, 1'b1);
        bus_access(1, 32'h8001_7FFF);
        chk("lhu_sel", 32'(cap_sel), 32'b1100);
        chk("lhu_wdata", mem_wdata, 32'h0000_8001);
        tick();

        // Stores with lane replication
        set_op(OP_SH, 32'h2002, 32'h0000_ABCD, 5'd0, 1'b0);
        bus_access(1, 32'h0);
        chk("sh_we", 32'(cap_we), 32'd1);
        chk("sh_sel", 32'(cap_sel), 32'b0011);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_addr", cap_addr, 32'h2000);
        chk("sh_wreg", 32'(mem_wreg), 32'd0);
        tick();
        set_op(OP_SB, 32'h2001, 32'h0000_005A, 5'd0, 1'b0);
        bus_access(1, 32'h0);
        chk("sb_sel", 32'(cap_sel), 32'b0100);
        chk("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
        tick();

        // LL then SC with forwarded LLbit=1
        set_op(OP_LL, 32'h40, 32'h0, 5'd7, 1'b1);
        bus_access(2, 32'h1234_5678);
        chk("ll_stall_cycles", 32'(n), 32'd3);
        chk("ll_wdata", mem_wdata, 32'h1234_5678);
        chk("ll_wreg", 32'(mem_wreg), 32'd1);
        chk("ll_llwe", 32'(mem_LLbit_we), 32'd1);
        chk("ll_llval", 32'(mem_LLbit_value), 32'd1);
        tick();
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        set_op(OP_SC, 32'h40, 32'hCAFE_F00D, 5'd8, 1'b1);
        chk("sc_idle_stallreq", 32'(stallreq), 32'd1);
        bus_access(2, 32'h0);
        chk("sc_we", 32'(cap_we), 32'd1);
        chk("sc_sel", 32'(cap_sel), 32'b1111);
        chk("sc_wdata_bus", cap_wdata, 32'hCAFE_F00D);
        chk("sc_wdata", mem_wdata, 32'd1);
        chk("sc_wreg", 32'(mem_wreg), 32'd1);
        chk("sc_llwe", 32'(mem_LLbit_we), 32'd1);
        chk("sc_llval", 32'(mem_LLbit_value), 32'd0);
        tick();

        // SC with LLbit=0: no bus access, result 0
        wb_LLbit_we = 1'b0; LLbit_i = 1'b0;
        set_op(OP_SC, 32'h40, 32'hCAFE_F00D, 5'd8, 1'b1);
        chk("scf_stallreq", 32'(stallreq), 32'd0);
        chk("scf_wdata", mem_wdata, 32'd0);
        chk("scf_wreg", 32'(mem_wreg), 32'd1);
        tick();
        chk("scf_no_req", 32'(dbus_req), 32'd0);
        // Forwarded value overrides the LLbit register
        LLbit_i = 1'b1; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b0;
        #1;
        chk("scfwd_stallreq", 32'(stallreq), 32'd0);
        wb_LLbit_we = 1'b0;
        #1;
        chk("screg_stallreq", 32'(stallreq), 32'd1);
        set_op(OP_OR, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();

        // Misaligned accesses
        set_op(OP_LW, 32'h41, 32'h0, 5'd4, 1'b1);
        chk("lw_mis_stallreq", 32'(stallreq), 32'd0);
        chk("lw_mis_err", 32'(mem_err), 32'd1);
        chk("lw_mis_wreg", 32'(mem_wreg), 32'd0);
        tick();
        chk("lw_mis_no_req", 32'(dbus_req), 32'd0);
        set_op(OP_SC, 32'h42, 32'h0, 5'd4, 1'b1);
        chk("sc_mis_err", 32'(mem_err), 32'd1);
        chk("sc_mis_llwe", 32'(mem_LLbit_we), 32'd0);
        set_op(OP_LH, 32'h1001, 32'h0, 5'd4, 1'b1);
        chk("lh_mis_err", 32'(mem_err), 32'd1);
        chk("lh_mis_stallreq", 32'(stallreq), 32'd0);
        LLbit_i = 1'b0;
        tick();

        // Reset asserted mid-BUSY
        set_op(OP_LW, 32'h100, 32'h0, 5'd6, 1'b1);
        tick();
        chk("rstb_busy_req", 32'(dbus_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstb_req_drop", 32'(dbus_req), 32'd0);
        chk("rstb_stallreq", 32'(stallreq), 32'd0);
        chk("rstb_wreg", 32'(mem_wreg), 32'd0);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("rstb_idle_stallreq", 32'(stallreq), 32'd1);
        chk("rstb_idle_req", 32'(dbus_req), 32'd0);
        bus_access(1, 32'hA5A5_0F0F);
        chk("rstb_cycles", 32'(n), 32'd2);
        chk("rstb_addr", cap_addr, 32'h100);
        chk("rstb_wdata", mem_wdata, 32'hA5A5_0F0F);
        tick();

        // Timeout with DONE held by stall[4]
        stall = 6'b01_0000;
        set_op(OP_LW, 32'h300, 32'h0, 5'd2, 1'b1);
        bus_access(0, 32'h0);
        chk("to_busy_cycles", 32'(b), 32'd5);
        chk("to_stall_cycles", 32'(n), 32'd6);
        chk("to_req_drop", 32'(dbus_req), 32'd0);
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_wreg", 32'(mem_wreg), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("to_hold_err", 32'(mem_err), 32'd1);
            chk("to_hold_stallreq", 32'(stallreq), 32'd0);
            chk("to_hold_req", 32'(dbus_req), 32'd0);
        end
        stall = 6'b0;
        tick();
        chk("to_idle_stallreq", 32'(stallreq), 32'd1);
        chk("to_idle_err", 32'(mem_err), 32'd0);
        bus_access(1, 32'h0BAD_F00D);
        chk("to_retry_err", 32'(mem_err), 32'd0);
        chk("to_retry_wdata", mem_wdata, 32'h0BAD_F00D);
        chk("to_retry_wreg", 32'(mem_wreg), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
